ysyx_041461_mem_access: RTL and testbench



---
 rtl/ysyx_041461_mem_access_pkg.sv | 79 +++++++
 rtl/ysyx_041461_load_align.sv | 31 +++
 rtl/ysyx_041461_mem_access.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_041461_mem_access.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_mem_access_pkg.sv
// Shared encodings for the ysyx_041461 memory-access stage: memory control
// codes, trap codes, FSM states and small decode helpers.
package ysyx_041461_mem_access_pkg;

  // Memory control encodings carried in the MEM pipeline register.
  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LD  = 4'd4;
  localparam logic [3:0] MEM_LBU = 4'd5;
  localparam logic [3:0] MEM_LHU = 4'd6;
  localparam logic [3:0] MEM_LWU = 4'd7;
  localparam logic [3:0] MEM_SB  = 4'd8;
  localparam logic [3:0] MEM_SH  = 4'd9;
  localparam logic [3:0] MEM_SW  = 4'd10;
  localparam logic [3:0] MEM_SD  = 4'd11;

  // Trap codes (RISC-V exception cause numbers for the misaligned cases).
  localparam logic [3:0] TRAP_NOP         = 4'd0;
  localparam logic [3:0] TRAP_LD_MISALIGN = 4'd4;
  localparam logic [3:0] TRAP_ST_MISALIGN = 4'd6;

  // Bus access FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True for the seven load encodings.
  function automatic logic is_load(input logic [3:0] ctrl);
    logic r;
    case (ctrl)
      MEM_LB, MEM_LH, MEM_LW, MEM_LD,
      MEM_LBU, MEM_LHU, MEM_LWU: r = 1'b1;
      MEM_NOP:                   r = 1'b0;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the four store encodings.
  function automatic logic is_store(input logic [3:0] ctrl);
    logic r;
    case (ctrl)
      MEM_SB, MEM_SH, MEM_SW, MEM_SD: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Natural-alignment check on the low address bits for the access size.
  function automatic logic is_misaligned(input logic [3:0] ctrl, input logic [2:0] off);
    logic r;
    case (ctrl)
      MEM_LH, MEM_LHU, MEM_SH: r = (off[0] != 1'b0);
      MEM_LW, MEM_LWU, MEM_SW: r = (off[1:0] != 2'b00);
      MEM_LD, MEM_SD:          r = (off != 3'b000);
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

  // Unshifted byte-strobe pattern for a store of the given size.
  function automatic logic [7:0] strb_base(input logic [3:0] ctrl);
    logic [7:0] r;
    case (ctrl)
      MEM_SB:  r = 8'h01;
      MEM_SH:  r = 8'h03;
      MEM_SW:  r = 8'h0F;
      MEM_SD:  r = 8'hFF;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_041461_load_align.sv
// Load data alignment: shifts the 64-bit bus word down to the addressed byte
// and sign- or zero-extends according to the load type.
module ysyx_041461_load_align
  import ysyx_041461_mem_access_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_offset,
  input  logic [3:0]  i_ctrl,
  output logic [63:0] o_result
);

  logic [63:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Select and extend the low bytes of the shifted word per load type.
  always_comb begin
    o_result = 64'd0;
    case (i_ctrl)
      MEM_LB:  o_result = {{56{w_shifted[7]}},  w_shifted[7:0]};
      MEM_LH:  o_result = {{48{w_shifted[15]}}, w_shifted[15:0]};
      MEM_LW:  o_result = {{32{w_shifted[31]}}, w_shifted[31:0]};
      MEM_LD:  o_result = w_shifted;
      MEM_LBU: o_result = {56'd0, w_shifted[7:0]};
      MEM_LHU: o_result = {48'd0, w_shifted[15:0]};
      MEM_LWU: o_result = {32'd0, w_shifted[31:0]};
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_041461_mem_access.sv
// Memory-access stage of the ysyx_041461 pipeline. Non-memory, trapped and
// misaligned instructions bypass combinationally to WB; legal loads/stores
// run one request/response transaction and hold the pipeline until WB takes
// the result.
module ysyx_041461_mem_access
  import ysyx_041461_mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_trap,
  input  logic [63:0] in_exe,
  input  logic [3:0]  in_mem_ctrl,
  input  logic [4:0]  in_rd,
  input  logic [11:0] in_csr,
  input  logic [63:0] in_pc,
  input  logic [3:0]  in_wb_ctrl,
  input  logic [63:0] in_store_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_trap,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic [11:0] out_csr,
  output logic [63:0] out_pc,
  output logic [3:0]  out_wb_ctrl,
  output logic        stall_o,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  output logic        req_wen,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_req_addr;
  logic        r_req_wen;
  logic [63:0] r_req_wdata;
  logic [7:0]  r_req_wstrb;
  logic [2:0]  r_offset;
  logic [3:0]  r_ctrl;
  logic [63:0] r_result;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_trap_in;
  logic        w_access;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic [63:0] w_load_result;
  logic        w_out_valid;
  logic [3:0]  w_out_trap;
  logic [63:0] w_out_result;
  logic        w_stall;

  // Instruction decode from the MEM register.
  assign w_is_load  = is_load(in_mem_ctrl);
  assign w_is_store = is_store(in_mem_ctrl);
  assign w_misalign = is_misaligned(in_mem_ctrl, in_exe[2:0]);
  assign w_trap_in  = (in_trap != TRAP_NOP);
  assign w_access   = in_valid & (w_is_load | w_is_store) & ~w_trap_in & ~w_misalign;

  // Store lane placement; bits pushed past the top of the word are dropped.
  assign w_wstrb = w_is_store ? (strb_base(in_mem_ctrl) << in_exe[2:0]) : 8'h00;
  assign w_wdata = w_is_store ? (in_store_data << {in_exe[2:0], 3'b000}) : 64'd0;

  ysyx_041461_load_align u_load_align (
    .i_rdata  (rsp_rdata),
    .i_offset (r_offset),
    .i_ctrl   (r_ctrl),
    .o_result (w_load_result)
  );

  // FSM state register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus WB-facing outputs and stall for the current state.
  always_comb begin
    w_state_nxt  = r_state;
    w_out_valid  = 1'b0;
    w_out_trap   = TRAP_NOP;
    w_out_result = in_exe;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_state_nxt = ST_REQ;
          w_stall     = in_valid;
        end else begin
          w_state_nxt = ST_IDLE;
          w_out_valid = in_valid;
          w_stall     = in_valid & ~out_ready;
          if (w_trap_in) begin
            w_out_trap = in_trap;
          end else if (w_misalign & w_is_load) begin
            w_out_trap = TRAP_LD_MISALIGN;
          end else if (w_misalign & w_is_store) begin
            w_out_trap = TRAP_ST_MISALIGN;
          end else begin
            w_out_trap = TRAP_NOP;
          end
        end
      end
      ST_REQ: begin
        w_stall = in_valid;
        if (req_ready) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_RESP: begin
        w_stall = in_valid;
        if (rsp_valid) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_DONE: begin
        w_out_valid  = 1'b1;
        w_out_result = r_result;
        w_stall      = in_valid & ~out_ready;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request fields latched at issue and the completed result latched on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_addr  <= 64'd0;
      r_req_wen   <= 1'b0;
      r_req_wdata <= 64'd0;
      r_req_wstrb <= 8'h00;
      r_offset    <= 3'd0;
      r_ctrl      <= MEM_NOP;
      r_result    <= 64'd0;
    end else begin
      if ((r_state == ST_IDLE) && w_access) begin
        r_req_addr  <= {in_exe[63:3], 3'b000};
        r_req_wen   <= w_is_store;
        r_req_wdata <= w_wdata;
        r_req_wstrb <= w_wstrb;
        r_offset    <= in_exe[2:0];
        r_ctrl      <= in_mem_ctrl;
      end
      if ((r_state == ST_RESP) && rsp_valid) begin
        r_result <= r_req_wen ? 64'd0 : w_load_result;
      end
    end
  end

  // req_valid is a pure decode of the registered state.
  assign req_valid = (r_state == ST_REQ);
  assign req_addr  = r_req_addr;
  assign req_wen   = r_req_wen;
  assign req_wdata = r_req_wdata;
  assign req_wstrb = r_req_wstrb;

  // While reset is held, the combinational outputs are forced to their idle values.
  assign out_valid  = w_out_valid & rst_n;
  assign out_trap   = rst_n ? w_out_trap : TRAP_NOP;
  assign out_result = rst_n ? w_out_result : 64'd0;
  assign stall_o    = w_stall & rst_n;

  assign out_rd      = in_rd;
  assign out_csr     = in_csr;
  assign out_pc      = in_pc;
  assign out_wb_ctrl = in_wb_ctrl;

endmodule

// File: tb/tb_ysyx_041461_mem_access.sv
// Self-checking bench for ysyx_041461_mem_access: directed scenarios plus
// randomized accesses against a byte-level reference model.
module tb_ysyx_041461_mem_access;
  import ysyx_041461_mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_trap;
  logic [63:0] in_exe;
  logic [3:0]  in_mem_ctrl;
  logic [4:0]  in_rd;
  logic [11:0] in_csr;
  logic [63:0] in_pc;
  logic [3:0]  in_wb_ctrl;
  logic [63:0] in_store_data;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_trap;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic [11:0] out_csr;
  logic [63:0] out_pc;
  logic [3:0]  out_wb_ctrl;
  logic        stall_o;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;

  int nvec = 0;
  int nerr = 0;

  ysyx_041461_mem_access dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_trap(in_trap), .in_exe(in_exe),
    .in_mem_ctrl(in_mem_ctrl), .in_rd(in_rd), .in_csr(in_csr), .in_pc(in_pc),
    .in_wb_ctrl(in_wb_ctrl), .in_store_data(in_store_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_trap(out_trap), .out_result(out_result), .out_rd(out_rd),
    .out_csr(out_csr), .out_pc(out_pc), .out_wb_ctrl(out_wb_ctrl), .stall_o(stall_o),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  // Access size in bytes (0 for non-memory codes).
  function automatic int acc_size(input logic [3:0] ctrl);
    case (ctrl)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      4'd4, 4'd11:       return 8;
      default:           return 0;
    endcase
  endfunction

  // Byte-level reference: what the bus should see and what WB should get.
  function automatic void ref_model(input logic [3:0] ctrl, input logic [63:0] addr,
                                    input logic [63:0] sdata, input logic [63:0] rdata,
                                    output logic [63:0] e_addr, output logic [63:0] e_wdata,
                                    output logic [63:0] e_result, output logic [7:0] e_wstrb,
                                    output logic e_wen);
    int n, off, strb;
    bit sgn;
    logic [63:0] mask, val;
    n   = acc_size(ctrl);
    sgn = (ctrl == 4'd1) || (ctrl == 4'd2) || (ctrl == 4'd3);
    off = int'(addr % 64'd8);
    e_addr = addr - 64'(off);
    if (ctrl >= 4'd8) begin
      e_wen    = 1'b1;
      strb     = ((1 << n) - 1) << off;
      e_wstrb  = 8'(strb & 255);
      e_wdata  = sdata << (8 * off);
      e_result = 64'd0;
    end else begin
      e_wen   = 1'b0;
      e_wstrb = 8'h00;
      e_wdata = 64'd0;
      val     = rdata >> (8 * off);
      mask    = (n == 8) ? ~64'd0 : ((64'd1 << (8 * n)) - 64'd1);
      val     = val & mask;
      if (sgn && (((val >> (8 * n - 1)) & 64'd1) == 64'd1)) val = val | ~mask;
      e_result = val;
    end
  endfunction

  // Drives one load/store through the bus protocol and records what was seen.
  // Bench phases: 0 issue cycle, 1 request, 2 response wait, 3 result to WB.
  task automatic do_access(input logic [3:0] ctrl, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic [63:0] rdata,
                           input int req_w, input int rsp_w, input int out_w, input bit noise,
                           output int done_cyc, output logic [63:0] o_addr,
                           output logic [63:0] o_wdata, output logic [7:0] o_wstrb,
                           output logic o_wen, output logic [63:0] o_result,
                           output logic [3:0] o_trap, output int proto_err, output bit timeout);
    int phase, cnt, cyc;
    bit done, first, res_seen;
    in_valid = 1'b1; in_mem_ctrl = ctrl; in_exe = addr; in_store_data = sdata;
    in_trap = TRAP_NOP; in_rd = 5'($urandom); in_csr = 12'($urandom);
    in_pc = {$urandom, $urandom}; in_wb_ctrl = 4'($urandom);
    phase = 0; cnt = 0; cyc = 0; done = 1'b0; first = 1'b1; res_seen = 1'b0;
    proto_err = 0; timeout = 1'b0; done_cyc = -1;
    o_addr = 64'd0; o_wdata = 64'd0; o_wstrb = 8'h00; o_wen = 1'b0; o_result = 64'd0; o_trap = TRAP_NOP;
    while (!done && !timeout) begin
      req_ready = (phase == 1) ? (cnt >= req_w) : (noise ? 1'($urandom) : 1'b0);
      rsp_valid = (phase == 2) ? (cnt >= rsp_w) : (noise ? 1'($urandom) : 1'b0);
      rsp_rdata = (phase == 2) ? rdata : {$urandom, $urandom};
      out_ready = (phase == 3) ? (cnt >= out_w) : (noise ? 1'($urandom) : 1'b0);
      #1;
      if (req_valid !== (phase == 1)) proto_err++;
      if (out_valid !== (phase == 3)) proto_err++;
      if (stall_o !== !((phase == 3) && out_ready)) proto_err++;
      if (phase == 1) begin
        if (first) begin
          o_addr = req_addr; o_wdata = req_wdata; o_wstrb = req_wstrb; o_wen = req_wen;
          first = 1'b0;
        end else if (req_addr !== o_addr || req_wdata !== o_wdata ||
                     req_wstrb !== o_wstrb || req_wen !== o_wen) begin
          proto_err++;
        end
      end
      if (phase == 3) begin
        if (res_seen && (out_result !== o_result)) proto_err++;
        o_result = out_result; o_trap = out_trap; res_seen = 1'b1;
      end
      if (phase == 0) begin
        phase = 1; cnt = 0;
      end else if (phase == 1) begin
        if (req_ready) begin phase = 2; cnt = 0; end else cnt++;
      end else if (phase == 2) begin
        if (rsp_valid) begin phase = 3; cnt = 0; end else cnt++;
      end else begin
        if (out_ready) begin done = 1'b1; done_cyc = cyc; end else cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) timeout = 1'b1;
    end
    req_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_mem_ctrl = MEM_LW; in_exe = 64'h8000_0000; in_trap = TRAP_NOP;
    out_ready = 1'b0;
    #1;
    nvec++; if (req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    nvec++; if (req_addr !== 64'd0) begin nerr++; $display("FAIL reset_req_addr got %h want 0", req_addr); end
    nvec++; if (req_wen !== 1'b0) begin nerr++; $display("FAIL reset_req_wen got %b want 0", req_wen); end
    nvec++; if (req_wdata !== 64'd0) begin nerr++; $display("FAIL reset_req_wdata got %h want 0", req_wdata); end
    nvec++; if (req_wstrb !== 8'h00) begin nerr++; $display("FAIL reset_req_wstrb got %h want 0", req_wstrb); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (out_trap !== TRAP_NOP) begin nerr++; $display("FAIL reset_out_trap got %h want %h", out_trap, TRAP_NOP); end
    nvec++; if (out_result !== 64'd0) begin nerr++; $display("FAIL reset_out_result got %h want 0", out_result); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", stall_o); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    int dc, pe; bit to; logic [63:0] a, wd, r; logic [7:0] ws; logic we; logic [3:0] tr;
    do_access(MEM_LW, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 0, 1'b0,
              dc, a, wd, ws, we, r, tr, pe, to);
    in_valid = 1'b0;
    nvec++; if (to) begin nerr++; $display("FAIL lw_timeout got timeout want completion"); end
    nvec++; if (a !== 64'h8000_0000) begin nerr++; $display("FAIL lw_addr got %h want 80000000", a); end
    nvec++; if (ws !== 8'h00) begin nerr++; $display("FAIL lw_wstrb got %h want 00", ws); end
    nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL lw_wen got %b want 0", we); end
    nvec++; if (r !== 64'hFFFF_FFFF_8765_4321) begin nerr++; $display("FAIL lw_result got %h want ffffffff87654321", r); end
    nvec++; if (dc !== 3) begin nerr++; $display("FAIL lw_latency got %0d want 3", dc); end
    nvec++; if (pe !== 0) begin nerr++; $display("FAIL lw_protocol got %0d errors want 0", pe); end
  endtask

  task automatic test_sb();
    int dc, pe; bit to; logic [63:0] a, wd, r; logic [7:0] ws; logic we; logic [3:0] tr;
    do_access(MEM_SB, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 1'b0,
              dc, a, wd, ws, we, r, tr, pe, to);
    in_valid = 1'b0;
    nvec++; if (ws !== 8'h08) begin nerr++; $display("FAIL sb_wstrb got %h want 08", ws); end
    nvec++; if (wd[31:24] !== 8'hAB) begin nerr++; $display("FAIL sb_wdata got %h want AB in [31:24]", wd); end
    nvec++; if (we !== 1'b1) begin nerr++; $display("FAIL sb_wen got %b want 1", we); end
    nvec++; if (r !== 64'd0) begin nerr++; $display("FAIL sb_result got %h want 0", r); end
    nvec++; if (tr !== TRAP_NOP) begin nerr++; $display("FAIL sb_trap got %h want %h", tr, TRAP_NOP); end
    nvec++; if (dc !== 3 || pe !== 0 || to) begin nerr++; $display("FAIL sb_timing got cyc %0d err %0d to %0b want 3 0 0", dc, pe, to); end
  endtask

  task automatic test_lbu_waits();
    int dc, pe; bit to; logic [63:0] a, wd, r; logic [7:0] ws; logic we; logic [3:0] tr;
    do_access(MEM_LBU, 64'h8000_0007, 64'd0, 64'hF234_5678_9ABC_DEF0, 3, 2, 0, 1'b1,
              dc, a, wd, ws, we, r, tr, pe, to);
    in_valid = 1'b0;
    nvec++; if (dc !== 8) begin nerr++; $display("FAIL lbu_latency got %0d want 8", dc); end
    nvec++; if (pe !== 0 || to) begin nerr++; $display("FAIL lbu_protocol got %0d errors to %0b want 0", pe, to); end
    nvec++; if (r !== 64'h0000_0000_0000_00F2) begin nerr++; $display("FAIL lbu_result got %h want f2", r); end
    nvec++; if (a !== 64'h8000_0000) begin nerr++; $display("FAIL lbu_addr got %h want 80000000", a); end
  endtask

  task automatic test_misalign();
    in_valid = 1'b1; in_mem_ctrl = MEM_LD; in_exe = 64'h8000_0004; in_trap = TRAP_NOP; out_ready = 1'b1;
    #1;
    nvec++; if (out_trap !== TRAP_LD_MISALIGN) begin nerr++; $display("FAIL ld_mis_trap got %h want %h", out_trap, TRAP_LD_MISALIGN); end
    nvec++; if (out_valid !== 1'b1 || stall_o !== 1'b0) begin nerr++; $display("FAIL ld_mis_valid got v%b s%b want v1 s0", out_valid, stall_o); end
    nvec++; if (out_result !== 64'h8000_0004) begin nerr++; $display("FAIL ld_mis_result got %h want 80000004", out_result); end
    @(posedge clk); #1;
    nvec++; if (req_valid !== 1'b0) begin nerr++; $display("FAIL ld_mis_noreq got %b want 0", req_valid); end
    in_mem_ctrl = MEM_SW; in_exe = 64'h8000_0006;
    #1;
    nvec++; if (out_trap !== TRAP_ST_MISALIGN) begin nerr++; $display("FAIL sw_mis_trap got %h want %h", out_trap, TRAP_ST_MISALIGN); end
    @(posedge clk); #1;
    nvec++; if (req_valid !== 1'b0) begin nerr++; $display("FAIL sw_mis_noreq got %b want 0", req_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_bypass_stall();
    in_valid = 1'b1; in_mem_ctrl = MEM_NOP; in_exe = 64'd5; in_trap = TRAP_NOP; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      nvec++; if (stall_o !== 1'b1) begin nerr++; $display("FAIL add_stall_c%0d got %b want 1", c, stall_o); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL add_release got %b want 0", stall_o); end
    nvec++; if (out_result !== 64'd5 || out_valid !== 1'b1) begin nerr++; $display("FAIL add_result got %h v%b want 5 v1", out_result, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_random_bypass();
    logic [3:0] ctrl, trap, etrap; logic [63:0] addr; int kind, n;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      addr = {$urandom, $urandom};
      trap = TRAP_NOP;
      if (kind == 0) begin
        ctrl = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(12, 15));
      end else if (kind == 1) begin
        ctrl = 4'($urandom_range(0, 15));
        trap = 4'($urandom_range(1, 15));
      end else begin
        ctrl = 4'($urandom_range(1, 11));
        n = acc_size(ctrl);
        if (n == 1) ctrl = ctrl + 4'd1;
        n = acc_size(ctrl);
        if ((addr % 64'(n)) == 64'd0) addr = addr + 64'd1;
      end
      n = acc_size(ctrl);
      if (trap != TRAP_NOP) etrap = trap;
      else if (n > 1 && (addr % 64'(n)) != 64'd0) etrap = (ctrl >= 4'd8) ? TRAP_ST_MISALIGN : TRAP_LD_MISALIGN;
      else etrap = TRAP_NOP;
      in_valid = 1'b1; in_mem_ctrl = ctrl; in_exe = addr; in_trap = trap; out_ready = 1'($urandom);
      #1;
      nvec++; if (out_trap !== etrap) begin nerr++; $display("FAIL byp_trap[%0d] got %h want %h", i, out_trap, etrap); end
      nvec++; if (out_result !== addr || out_valid !== 1'b1) begin nerr++; $display("FAIL byp_pass[%0d] got %h v%b want %h v1", i, out_result, out_valid, addr); end
      nvec++; if (stall_o !== !out_ready) begin nerr++; $display("FAIL byp_stall[%0d] got %b want %b", i, stall_o, !out_ready); end
      @(posedge clk); #1;
      nvec++; if (req_valid !== 1'b0) begin nerr++; $display("FAIL byp_noreq[%0d] got %b want 0", i, req_valid); end
    end
    in_valid = 1'b0; in_trap = TRAP_NOP; out_ready = 1'b0;
  endtask

  task automatic test_random_access();
    int dc, pe, n; bit to; logic [63:0] a, wd, r, addr, sd, rd, ea, ewd, er;
    logic [7:0] ws, ews; logic we, ewe; logic [3:0] tr, ctrl;
    for (int i = 0; i < 40; i++) begin
      ctrl = 4'($urandom_range(1, 11));
      n = acc_size(ctrl);
      addr = {$urandom, $urandom};
      addr = addr - (addr % 64'(n));
      sd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      ref_model(ctrl, addr, sd, rd, ea, ewd, er, ews, ewe);
      do_access(ctrl, addr, sd, rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1,
                dc, a, wd, ws, we, r, tr, pe, to);
      nvec++; if (pe !== 0 || to) begin nerr++; $display("FAIL rnd_protocol[%0d] ctrl %0d got %0d errors to %0b want 0", i, ctrl, pe, to); end
      nvec++; if (a !== ea || we !== ewe || ws !== ews) begin nerr++; $display("FAIL rnd_req[%0d] ctrl %0d got %h %b %h want %h %b %h", i, ctrl, a, we, ws, ea, ewe, ews); end
      if (ewe) begin
        nvec++; if (wd !== ewd) begin nerr++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, wd, ewd); end
      end
      nvec++; if (r !== er || tr !== TRAP_NOP) begin nerr++; $display("FAIL rnd_result[%0d] ctrl %0d off %0d got %h trap %h want %h", i, ctrl, addr % 64'd8, r, tr, er); end
      nvec++; if (out_rd !== in_rd || out_pc !== in_pc || out_csr !== in_csr || out_wb_ctrl !== in_wb_ctrl) begin
        nerr++; $display("FAIL rnd_passthru[%0d] got %h %h want %h %h", i, out_rd, out_pc, in_rd, in_pc);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_resp();
    int dc, pe; bit to; logic [63:0] a, wd, r; logic [7:0] ws; logic we; logic [3:0] tr;
    in_valid = 1'b1; in_mem_ctrl = MEM_LW; in_exe = 64'h8000_0010; in_trap = TRAP_NOP;
    req_ready = 1'b1; rsp_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    nvec++; if (req_valid !== 1'b1) begin nerr++; $display("FAIL rmid_req got %b want 1", req_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    nvec++; if (req_valid !== 1'b0 || out_valid !== 1'b0 || stall_o !== 1'b0) begin
      nerr++; $display("FAIL rmid_ctrl got rv%b ov%b st%b want 0 0 0", req_valid, out_valid, stall_o);
    end
    nvec++; if (req_addr !== 64'd0 || req_wstrb !== 8'h00 || req_wen !== 1'b0 || req_wdata !== 64'd0 ||
                out_result !== 64'd0 || out_trap !== TRAP_NOP) begin
      nerr++; $display("FAIL rmid_vals got addr %h res %h trap %h want 0 0 0", req_addr, out_result, out_trap);
    end
    in_valid = 1'b0; req_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b1; rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      nvec++; if (out_valid !== 1'b0 || req_valid !== 1'b0 || stall_o !== 1'b0) begin
        nerr++; $display("FAIL rmid_stray_c%0d got ov%b rv%b st%b want 0 0 0", c, out_valid, req_valid, stall_o);
      end
      @(posedge clk); #1;
    end
    do_access(MEM_LD, 64'h8000_0018, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1, 1, 1'b0,
              dc, a, wd, ws, we, r, tr, pe, to);
    in_valid = 1'b0;
    nvec++; if (r !== 64'h0123_4567_89AB_CDEF || pe !== 0 || to) begin
      nerr++; $display("FAIL rmid_recover got %h err %0d want 0123456789abcdef 0", r, pe);
    end
  endtask

  task automatic test_back_to_back();
    int dc, pe; bit to; logic [63:0] a, wd, r; logic [7:0] ws; logic we; logic [3:0] tr;
    do_access(MEM_LH, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 0, 0, 0, 1'b0,
              dc, a, wd, ws, we, r, tr, pe, to);
    nvec++; if (r !== 64'hFFFF_FFFF_FFFF_8001 || pe !== 0) begin nerr++; $display("FAIL b2b_lh got %h err %0d want ffffffffffff8001", r, pe); end
    do_access(MEM_SD, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 0, 0, 0, 1'b0,
              dc, a, wd, ws, we, r, tr, pe, to);
    nvec++; if (ws !== 8'hFF || wd !== 64'h1122_3344_5566_7788 || a !== 64'h8000_0008 || pe !== 0) begin
      nerr++; $display("FAIL b2b_sd got %h %h %h err %0d want ff 1122334455667788 80000008", ws, wd, a, pe);
    end
    do_access(MEM_SH, 64'h8000_000E, 64'h0000_0000_0000_BEEF, 64'd0, 0, 0, 0, 1'b0,
              dc, a, wd, ws, we, r, tr, pe, to);
    in_valid = 1'b0;
    nvec++; if (ws !== 8'hC0 || wd !== 64'hBEEF_0000_0000_0000 || pe !== 0) begin
      nerr++; $display("FAIL b2b_sh got %h %h err %0d want c0 beef000000000000", ws, wd, pe);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_trap = TRAP_NOP; in_exe = 64'd0; in_mem_ctrl = MEM_NOP;
    in_rd = 5'd0; in_csr = 12'd0; in_pc = 64'd0; in_wb_ctrl = 4'd0; in_store_data = 64'd0;
    out_ready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 64'd0;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_sb();
    test_lbu_waits();
    test_misalign();
    test_bypass_stall();
    test_random_bypass();
    test_back_to_back();
    test_random_access();
    test_reset_mid_resp();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
